// File: rtl/psum_drain.sv
// psum_drain: de-skews bottom-row psums into aligned vectors, optional ReLU, FWFT FIFO out.
// Ports: clk/rst (sync, active-high); start/len/relu_en launch a capture; psum_in skewed
// column psums; out_valid/out_ready/out_data FIFO head handshake; busy, done, overflow status.
module psum_drain #(
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   relu_en,
  input  logic [COLS*DATA_W-1:0] psum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*DATA_W-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, CAPT, FLUSH} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt, cnt_nx, len_r;
  logic relu_r, accept, v0, fsm_done, zdone, push, pop, full, empty, wr;
  logic [COLS-2:0] vd;
  logic [AW:0] wp, rp;
  logic [COLS*DATA_W-1:0] aligned, relu_vec;
  logic [COLS*DATA_W-1:0] mem [DEPTH];
  // CAPT spends one cycle per row after row 0 plus one cycle to notice the count is reached;
  // FLUSH then reuses cnt to time out the remaining skew so done lands on the right cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    v0       = 1'b0;
    fsm_done = state == FLUSH && cnt == LEN_W'(COLS-1);
    accept   = start && len != '0 && (state == IDLE || fsm_done);
    if (state == CAPT) begin
      v0       = cnt != len_r;
      cnt_nx   = cnt == len_r ? LEN_W'(1) : cnt + LEN_W'(1);
      state_nx = cnt == len_r ? FLUSH : CAPT;
    end else if (state == FLUSH) begin
      cnt_nx   = cnt + LEN_W'(1);
      state_nx = fsm_done ? IDLE : FLUSH;
    end
    if (accept) begin
      state_nx = CAPT;
      cnt_nx   = LEN_W'(1);
      v0       = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      len_r  <= '0;
      relu_r <= 1'b0;
      zdone  <= 1'b0;
      vd     <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      len_r  <= accept ? len : len_r;
      relu_r <= accept ? relu_en : relu_r;
      zdone  <= start && len == '0 && (state == IDLE || fsm_done);
      vd     <= (COLS-1)'({vd, v0});
    end
  end
  assign busy = state != IDLE;
  assign done = fsm_done | zdone;
  assign push = vd[COLS-2];
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int L = COLS - 1 - c;
    if (L == 0) begin : g_direct
      assign aligned[c*DATA_W +: DATA_W] = psum_in[c*DATA_W +: DATA_W];
    end else begin : g_delay
      logic [DATA_W-1:0] sh [L];
      always_ff @(posedge clk) begin
        if (rst) for (int i = 0; i < L; i++) sh[i] <= '0;
        else begin
          sh[0] <= psum_in[c*DATA_W +: DATA_W];
          for (int i = 1; i < L; i++) sh[i] <= sh[i-1];
        end
      end
      assign aligned[c*DATA_W +: DATA_W] = sh[L-1];
    end
    assign relu_vec[c*DATA_W +: DATA_W] = (relu_r && aligned[c*DATA_W + DATA_W - 1]) ? '0 : aligned[c*DATA_W +: DATA_W];
  end
  assign empty     = wp == rp;
  assign full      = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign pop       = !empty && out_ready;
  assign wr        = push && (!full || pop);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) if (wr) mem[wp[AW-1:0]] <= relu_vec;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      wp       <= wp + (AW+1)'(wr);
      rp       <= rp + (AW+1)'(pop);
      overflow <= overflow | (push & full & !pop);
    end
  end
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed self-checking bench for psum_drain.
module tb_psum_drain;
  logic clk = 0, rst, start, relu_en, out_ready, out_valid, busy, done, overflow;
  logic [7:0] len;
  logic [63:0] psum_in, out_data;
  int checks = 0, errors = 0;

  psum_drain dut (.clk(clk), .rst(rst), .start(start), .len(len), .relu_en(relu_en),
    .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rowvec(input int k);
    logic [63:0] v;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = 16'(10*k + c);
    return v;
  endfunction

  function automatic logic [63:0] skewed(input int n, input int l);
    logic [63:0] v;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = (n-c >= 0 && n-c < l) ? 16'(10*(n-c) + c) : 16'h0BAD;
    return v;
  endfunction

  task automatic run_basic(input bit second);
    for (int n = 0; n <= 8; n++) begin
      start = (n == 0) || (second && n == 2);
      len = 3; relu_en = 0; out_ready = 1;
      psum_in = skewed(n, 3);
      chk($sformatf("basic%0d_valid_n%0d", second, n), out_valid, n >= 4 && n <= 6);
      if (n >= 4 && n <= 6) chk($sformatf("basic%0d_data_n%0d", second, n), out_data, rowvec(n-4));
      chk($sformatf("basic%0d_done_n%0d", second, n), done, n == 6);
      chk($sformatf("basic%0d_busy_n%0d", second, n), busy, n >= 1 && n <= 6);
      tick();
    end
    start = 0; psum_in = '0;
  endtask

  task automatic run_relu(input bit r, input logic [63:0] exp);
    for (int n = 0; n <= 5; n++) begin
      start = n == 0; len = 1; relu_en = r; out_ready = 1;
      for (int c = 0; c < 4; c++) psum_in[c*16 +: 16] = (n == c) ? ((c == 2) ? 16'hFFFB : 16'h0007) : 16'h0000;
      chk($sformatf("relu%0d_valid_n%0d", r, n), out_valid, n == 4);
      if (n == 4) chk($sformatf("relu%0d_data", r), out_data, exp);
      chk($sformatf("relu%0d_done_n%0d", r, n), done, n == 4);
      tick();
    end
    start = 0; psum_in = '0;
  endtask

  initial begin
    rst = 1; start = 0; len = 0; relu_en = 0; out_ready = 0; psum_in = '0;
    tick(); tick();
    rst = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    tick();

    run_basic(0);
    tick();
    run_basic(1);
    tick();

    run_relu(1, 64'h0007_0000_0007_0007);
    run_relu(0, 64'h0007_FFFB_0007_0007);

    for (int n = 0; n <= 14; n++) begin
      start = n == 0; len = 10; relu_en = 0; out_ready = 0;
      psum_in = skewed(n, 10);
      if (n == 5 || n == 8) chk($sformatf("hold_data_n%0d", n), out_data, rowvec(0));
      if (n == 11 || n == 12) chk($sformatf("ovf_n%0d", n), overflow, n == 12);
      if (n >= 12) chk($sformatf("ovf_done_n%0d", n), done, n == 13);
      tick();
    end
    start = 0; psum_in = '0; out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_valid_%0d", k), out_valid, 1);
      chk($sformatf("drain_data_%0d", k), out_data, rowvec(k));
      tick();
    end
    chk("drain_empty", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    tick();

    for (int n = 0; n <= 2; n++) begin
      start = n == 0; len = 0;
      chk($sformatf("len0_done_n%0d", n), done, n == 1);
      chk($sformatf("len0_busy_n%0d", n), busy, 0);
      chk($sformatf("len0_valid_n%0d", n), out_valid, 0);
      tick();
    end
    start = 0;

    for (int n = 0; n <= 3; n++) begin
      start = n == 0; len = 5; relu_en = 0; out_ready = 1;
      psum_in = skewed(n, 5);
      if (n == 3) begin
        chk("abort_busy_before", busy, 1);
        rst = 1;
      end
      tick();
    end
    rst = 0; start = 0; psum_in = '0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovf_clr", overflow, 0);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("abort_nodone_%0d", n), done, 0);
      chk($sformatf("abort_nopush_%0d", n), out_valid, 0);
      tick();
    end
    run_basic(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
